// File: rtl/fifo_pkg.sv
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and helpers for the synchronous fifo family
//               and its stream read adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Default data width and storage depth of the attached fifo
    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_DEPTH     = 8;

    // Smallest skid buffer that still sustains one word per cycle
    localparam int MIN_SKID_DEPTH = 2;

    // Pointer width needed to index 'depth' entries (never narrower than 1)
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
// ============================================================================
// Module      : fifo_stream_reader_if
// Description : FIFO read port plus downstream valid/ready stream, bundled
//               for the fifo_stream_reader adapter.
//               master : the adapter's view (drives rd_en and the stream)
//               slave  : the fifo/consumer side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
);
    logic [WIDTH-1:0] fifo_dout_i;
    logic             fifo_empty_i;
    logic             fifo_rd_en_o;
    logic [WIDTH-1:0] m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;

    modport master (
        input  fifo_dout_i,
        input  fifo_empty_i,
        input  m_ready_i,
        output fifo_rd_en_o,
        output m_data_o,
        output m_valid_o
    );

    modport slave (
        output fifo_dout_i,
        output fifo_empty_i,
        output m_ready_i,
        input  fifo_rd_en_o,
        input  m_data_o,
        input  m_valid_o
    );

endinterface

`default_nettype wire

// File: rtl/fifo_stream_skid.sv
// ============================================================================
// Module      : fifo_stream_skid
// Description : Small circular skid buffer. Pushes land at the write pointer,
//               the head entry is always presented on o_head_data, and a pop
//               advances the read pointer. Push and pop in the same cycle
//               leave the occupancy unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_skid
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = MIN_SKID_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic      [CNT_W-1:0] o_count,
    output logic      [WIDTH-1:0] o_head_data
);

    localparam int               c_ptr_w    = ptr_width(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [c_ptr_w-1:0] w_wr_ptr_nxt;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;

    // Pointers wrap at DEPTH, which need not be a power of two
    assign w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= w_wr_ptr_nxt;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count     = r_count;
    assign o_head_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module      : fifo_stream_reader
// Description : Read-side adapter for the synchronous fifo. Issues fifo reads
//               against a credit count, absorbs the one-cycle read latency in
//               a skid buffer and presents the words as a valid/ready stream
//               at up to one word per cycle, in fifo order.
// Options     : FIFO_STREAM_READER_CNT_EN - adds xfer_cnt_o, a 16-bit
//               wrapping count of stream handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BUF_DEPTH = MIN_SKID_DEPTH
) (
    input  wire logic clk_i,
    input  wire logic reset_i,
    fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    output logic [15:0] xfer_cnt_o
`endif
);

    localparam int             c_cnt_w = $clog2(BUF_DEPTH + 1);
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(BUF_DEPTH);

    logic               r_inflight;
    logic [c_cnt_w-1:0] w_buf_count;
    logic [WIDTH-1:0]   w_head_data;
    logic               w_pop;
    logic               w_rd_en;
    logic [c_cnt_w:0]   w_credit_used;

    assign w_pop = bus.m_valid_o & bus.m_ready_i;

    // Entries committed after this edge: buffered + in flight - leaving now.
    // A pop implies buf_count >= 1, so this never underflows. Deliberately
    // combinational from m_ready_i so a full buffer being drained can still
    // read in the same cycle and keep the stream gap-free.
    assign w_credit_used = {1'b0, w_buf_count}
                         + {{c_cnt_w{1'b0}}, r_inflight}
                         - {{c_cnt_w{1'b0}}, w_pop};

    assign w_rd_en = !reset_i && !bus.fifo_empty_i && (w_credit_used < c_depth);

    // A read issued this cycle returns its word on fifo_dout_i next cycle
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    fifo_stream_skid #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk         (clk_i),
        .rst         (reset_i),
        .i_push      (r_inflight),
        .i_push_data (bus.fifo_dout_i),
        .i_pop       (w_pop),
        .o_count     (w_buf_count),
        .o_head_data (w_head_data)
    );

    assign bus.fifo_rd_en_o = w_rd_en;
    assign bus.m_valid_o    = (w_buf_count != '0);
    assign bus.m_data_o     = w_head_data;

`ifdef FIFO_STREAM_READER_CNT_EN
    logic [15:0] r_xfer_cnt;

    // Count completed stream handshakes, wrapping naturally at 16 bits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_xfer_cnt <= 16'd0;
        end else if (w_pop) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt_o = r_xfer_cnt;
`endif

endmodule

`default_nettype wire
